// File: rtl/seq_divider4.sv
// seq_divider4: 4-bit unsigned restoring divider, one quotient bit per clock.
module seq_divider4 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Start,
  input  logic [3:0] Dividend,
  input  logic [3:0] Divisor,
  output logic [3:0] Quotient,
  output logic [3:0] Remainder,
  output logic       Busy,
  output logic       Done,
  output logic       DivByZero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q, state_d;
  logic [4:0] r_q, r_d, d_q, d_d, rs;
  logic [3:0] q_q, q_d, quo_q, quo_d, rem_q, rem_d;
  logic [1:0] cnt_q, cnt_d;
  logic       dbz_q, dbz_d;
  logic [5:0] t;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    rs      = {r_q[3:0], q_q[3]};
    // t[5] is the carry-out of rs + ~D + 1: set means no borrow
    t       = {1'b0, rs} + {1'b0, ~d_q} + 6'd1;
    unique case (state_q)
      IDLE: if (Start) begin
        if (Divisor != 4'd0) begin
          r_d     = '0;
          q_d     = Dividend;
          d_d     = {1'b0, Divisor};
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          quo_d   = 4'hF;
          rem_d   = Dividend;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        r_d   = t[5] ? t[4:0] : rs;
        q_d   = {q_q[2:0], t[5]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          quo_d   = q_d;
          rem_d   = r_d[3:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
endmodule

// File: tb/tb_seq_divider4.sv
// tb_seq_divider4: directed self-checking bench for seq_divider4.
module tb_seq_divider4;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Dividend = '0, Divisor = '0;
  logic [3:0] Quotient, Remainder;
  logic       Busy, Done, DivByZero;
  int checks = 0, errors = 0;

  seq_divider4 dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic div(input logic [3:0] a, input logic [3:0] b, input int eq, input int er);
    @(negedge clk);
    Start = 1'b1; Dividend = a; Divisor = b;
    tick();
    Start = 1'b0;
    if (b != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        chk("busy", Busy, 1);
        chk("done_early", Done, 0);
        tick();
      end
    end
    chk("done", Done, 1);
    chk("busy_in_done", Busy, 0);
    chk("quotient", Quotient, eq);
    chk("remainder", Remainder, er);
    chk("dbz", DivByZero, b == 4'd0 ? 1 : 0);
    tick();
    chk("done_clear", Done, 0);
    chk("busy_clear", Busy, 0);
  endtask

  initial begin
    int n;
    logic [3:0] a, b;
    #2;
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    @(negedge clk);
    reset_n = 1'b1;
    div(4'd13, 4'd4, 3, 1);
    div(4'd15, 4'd1, 15, 0);
    div(4'd7, 4'd9, 0, 7);
    div(4'd15, 4'd15, 1, 0);
    div(4'd0, 4'd5, 0, 0);
    div(4'd9, 4'd0, 15, 9);
    div(4'd6, 4'd3, 2, 0);
    // Start and operand changes during RUN must be ignored
    @(negedge clk);
    Start = 1'b1; Dividend = 4'd14; Divisor = 4'd3;
    tick();
    Start = 1'b0;
    tick();
    Start = 1'b1; Dividend = 4'd8; Divisor = 4'd2;
    tick();
    Start = 1'b0;
    tick();
    chk("ign_busy", Busy, 1);
    tick();
    chk("ign_done", Done, 1);
    chk("ign_q", Quotient, 4);
    chk("ign_r", Remainder, 2);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("ign_no_second_done", Done, 0);
    end
    // asynchronous reset in the middle of a run
    @(negedge clk);
    Start = 1'b1; Dividend = 4'd11; Divisor = 4'd2;
    tick();
    Start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_q", Quotient, 0);
    chk("mid_rst_r", Remainder, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_dbz", DivByZero, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", Busy, 0);
    div(4'd11, 4'd2, 5, 1);
    // exhaustive sweep with Start held high
    @(negedge clk);
    Start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      Dividend = a; Divisor = b;
      n = 0;
      do begin
        tick();
        n++;
      end while (!Done && n < 12);
      chk("sweep_done", Done, 1);
      if (i > 0) chk("sweep_spacing", n, b == 4'd0 ? 2 : 6);
      if (b == 4'd0) begin
        chk("sweep_q0", Quotient, 15);
        chk("sweep_r0", Remainder, a);
        chk("sweep_dbz1", DivByZero, 1);
      end else begin
        chk("sweep_q", Quotient, a / b);
        chk("sweep_r", Remainder, a % b);
        chk("sweep_dbz0", DivByZero, 0);
      end
    end
    Start = 1'b0;
    tick();
    tick();
    chk("final_idle", Busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
